// File: rtl/arm_block_transfer_sequencer_pkg.sv
// Shared CPU decoder definitions used by the LDM/STM block-transfer sequencer.
package arm_block_transfer_sequencer_pkg;

  typedef enum logic {
    POST_OFFSET = 1'b0,
    PRE_OFFSET  = 1'b1
  } pre_post_offset_flag_t;

  // Encoded as {P, U}
  typedef enum logic [1:0] {
    DA = 2'b00,
    IA = 2'b01,
    DB = 2'b10,
    IB = 2'b11
  } block_mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    XFER   = 2'd1,
    FINISH = 2'd2
  } bts_state_t;

  localparam logic [31:0] EMPTY_LIST_STRIDE = 32'h40;

  function automatic block_mode_t block_mode(input pre_post_offset_flag_t p, input logic u);
    return block_mode_t'({p, u});
  endfunction

  // Lowest transfer address given the aligned base and the total block span.
  function automatic logic [31:0] block_start_addr(input block_mode_t m, input logic [31:0] b,
                                                   input logic [31:0] span);
    case (m)
      IA:      return b;
      IB:      return b + 32'd4;
      DA:      return b - span + 32'd4;
      default: return b - span;
    endcase
  endfunction

endpackage

// File: rtl/arm_block_transfer_sequencer_reg_list_scan.sv
// Lowest-set-bit finder and popcount over a 16-bit register list.
module reg_list_scan (
  input  logic [15:0] i_list,
  output logic [3:0]  o_idx,
  output logic [15:0] o_lowest,
  output logic [4:0]  o_count
);

  assign o_lowest = i_list & (~i_list + 16'd1);

  // Count set bits; descending scan so the lowest set index wins.
  always_comb begin
    o_idx   = '0;
    o_count = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i_list[i]) o_count = o_count + 5'd1;
    end
    for (int unsigned i = 16; i > 0; i--) begin
      if (i_list[i-1]) o_idx = 4'(i - 1);
    end
  end

endmodule

// File: rtl/arm_block_transfer_sequencer.sv
// LDM/STM sequencer: one word request per listed register, ascending order,
// with registered load writes and a single base writeback.
module arm_block_transfer_sequencer
  import arm_block_transfer_sequencer_pkg::*;
#(
  parameter bit EMPTY_LIST_QUIRK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_load,
  input  logic        P,
  input  logic        U,
  input  logic        S,
  input  logic        W,
  input  logic [15:0] reg_list,
  input  logic [3:0]  rn_idx,
  input  logic [31:0] base_addr,
  input  logic [31:0] store_data,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  reg_idx,
  output logic        rf_we,
  output logic [3:0]  rf_idx,
  output logic [31:0] rf_wdata,
  output logic        wb_we,
  output logic [31:0] wb_data,
  output logic        user_bank,
  output logic        load_pc,
  output logic        spsr_restore,
  output logic        done
);

  bts_state_t  r_state, w_next;
  block_mode_t r_mode;
  logic [15:0] r_list;
  logic [31:0] r_base, r_addr, r_rf_wdata, r_wb_data;
  logic [3:0]  r_rf_idx;
  logic        r_u, r_is_load, r_s, r_first, r_empty, r_user, r_wb_en, r_pc_listed;
  logic        r_rf_we, r_load_pc, r_wb_we;

  logic [3:0]  w_idx;
  logic [15:0] w_lowest, w_list_in;
  logic [4:0]  w_count;
  logic [31:0] w_span, w_cur_addr;
  logic        w_empty_in, w_ack;

  reg_list_scan u_scan (
    .i_list   (r_list),
    .o_idx    (w_idx),
    .o_lowest (w_lowest),
    .o_count  (w_count)
  );

  assign w_empty_in = (reg_list == '0);
  assign w_list_in  = (w_empty_in && EMPTY_LIST_QUIRK) ? 16'h8000 : reg_list;
  assign w_ack      = mem_ack && (r_state == XFER);
  // The remaining list is still full on the first transfer, so its popcount is n.
  assign w_span     = r_empty ? EMPTY_LIST_STRIDE : {25'd0, w_count, 2'b00};
  assign w_cur_addr = r_first ? block_start_addr(r_mode, r_base, w_span) : r_addr;

  assign mem_addr     = mem_req ? w_cur_addr : '0;
  assign mem_we       = mem_req && !r_is_load;
  assign reg_idx      = mem_req ? w_idx : '0;
  assign mem_wdata    = store_data;
  assign rf_we        = r_rf_we;
  assign rf_idx       = r_rf_idx;
  assign rf_wdata     = r_rf_wdata;
  assign load_pc      = r_load_pc;
  assign wb_we        = r_wb_we;
  assign wb_data      = r_wb_data;
  assign user_bank    = r_user;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_next       = r_state;
    busy         = 1'b0;
    mem_req      = 1'b0;
    done         = 1'b0;
    spsr_restore = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = (w_list_in == '0) ? FINISH : XFER;
      end
      XFER: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_ack && w_count == 5'd1) w_next = FINISH;
      end
      FINISH: begin
        busy         = 1'b1;
        done         = 1'b1;
        spsr_restore = r_s && r_is_load && r_pc_listed;
        w_next       = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand capture at launch, per-transfer bookkeeping and registered write ports.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode      <= IA;
      r_list      <= '0;
      r_base      <= '0;
      r_addr      <= '0;
      r_u         <= 1'b0;
      r_is_load   <= 1'b0;
      r_s         <= 1'b0;
      r_first     <= 1'b0;
      r_empty     <= 1'b0;
      r_user      <= 1'b0;
      r_wb_en     <= 1'b0;
      r_pc_listed <= 1'b0;
      r_rf_we     <= 1'b0;
      r_rf_idx    <= '0;
      r_rf_wdata  <= '0;
      r_load_pc   <= 1'b0;
      r_wb_we     <= 1'b0;
      r_wb_data   <= '0;
    end else begin
      r_rf_we   <= 1'b0;
      r_load_pc <= 1'b0;
      r_wb_we   <= 1'b0;
      if (r_state == IDLE && start) begin
        r_list      <= w_list_in;
        r_base      <= base_addr & 32'hFFFF_FFFC;
        r_mode      <= block_mode(pre_post_offset_flag_t'(P), U);
        r_u         <= U;
        r_is_load   <= is_load;
        r_s         <= S;
        r_first     <= 1'b1;
        r_empty     <= w_empty_in && EMPTY_LIST_QUIRK;
        r_user      <= S && !(is_load && reg_list[15]);
        r_wb_en     <= W && !(is_load && w_list_in[rn_idx]);
        r_pc_listed <= w_list_in[15];
      end
      if (w_ack) begin
        r_list  <= r_list & ~w_lowest;
        r_addr  <= w_cur_addr + 32'd4;
        r_first <= 1'b0;
        if (r_is_load) begin
          r_rf_we    <= 1'b1;
          r_rf_idx   <= w_idx;
          r_rf_wdata <= mem_rdata;
          r_load_pc  <= (w_idx == 4'd15);
        end
        if (r_first) begin
          r_wb_we   <= r_wb_en;
          r_wb_data <= r_u ? r_base + w_span : r_base - w_span;
        end
      end
      if (r_state == FINISH) r_user <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arm_block_transfer_sequencer.sv
// Self-checking bench for arm_block_transfer_sequencer: directed scenarios plus
// randomized operations checked against a transaction-level reference model.
module tb_arm_block_transfer_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, is_load, P, U, S, W, mem_ack;
  logic [15:0] reg_list;
  logic [3:0]  rn_idx;
  logic [31:0] base_addr, store_data, mem_rdata;
  logic        busy, mem_req, mem_we, rf_we, wb_we, user_bank, load_pc, spsr_restore, done;
  logic [31:0] mem_addr, mem_wdata, rf_wdata, wb_data;
  logic [3:0]  reg_idx, rf_idx;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  always #5 clk = ~clk;

  // Register file read port stand-in: each register holds a recognisable value.
  assign store_data = 32'h5A5A_0000 | {28'h0, reg_idx};

  arm_block_transfer_sequencer #(.EMPTY_LIST_QUIRK(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .is_load(is_load),
    .P(P), .U(U), .S(S), .W(W), .reg_list(reg_list), .rn_idx(rn_idx),
    .base_addr(base_addr), .store_data(store_data), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .busy(busy), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .reg_idx(reg_idx),
    .rf_we(rf_we), .rf_idx(rf_idx), .rf_wdata(rf_wdata), .wb_we(wb_we),
    .wb_data(wb_data), .user_bank(user_bank), .load_pc(load_pc),
    .spsr_restore(spsr_restore), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string ctx);
    chk({ctx, ".busy"}, busy, 0);
    chk({ctx, ".mem_req"}, mem_req, 0);
    chk({ctx, ".mem_we"}, mem_we, 0);
    chk({ctx, ".mem_addr"}, mem_addr, 0);
    chk({ctx, ".reg_idx"}, reg_idx, 0);
    chk({ctx, ".rf_we"}, rf_we, 0);
    chk({ctx, ".rf_idx"}, rf_idx, 0);
    chk({ctx, ".rf_wdata"}, rf_wdata, 0);
    chk({ctx, ".wb_we"}, wb_we, 0);
    chk({ctx, ".wb_data"}, wb_data, 0);
    chk({ctx, ".user_bank"}, user_bank, 0);
    chk({ctx, ".load_pc"}, load_pc, 0);
    chk({ctx, ".spsr_restore"}, spsr_restore, 0);
    chk({ctx, ".done"}, done, 0);
  endtask

  task automatic chk_writes(input bit pend_rf, input logic [3:0] pidx, input logic [31:0] pdata,
                            input bit pend_wb, input logic [31:0] wbd);
    chk("rf_we", rf_we, pend_rf);
    if (pend_rf) begin
      chk("rf_idx", rf_idx, pidx);
      chk("rf_wdata", rf_wdata, pdata);
    end
    chk("load_pc", load_pc, pend_rf && pidx == 4'd15);
    chk("wb_we", wb_we, pend_wb);
    if (pend_wb) chk("wb_data", wb_data, wbd);
  endtask

  // One LDM/STM operation. abort_at >= 0 asserts reset during that transfer.
  task automatic run_op(input bit ld, input bit a_p, input bit a_u, input bit a_s, input bit a_w,
                        input logic [15:0] list, input logic [3:0] rn, input logic [31:0] base,
                        input int unsigned maxwait, input bit junk_start, input int abort_at);
    int unsigned q[$];
    logic [15:0] eff;
    logic [31:0] b, span, addr, wbd, pdata;
    logic [3:0]  pidx;
    bit          wben, user_e, spsr_e, pend_rf, pend_wb, ack;
    int unsigned k, waited, nwait, cyc;

    // Reference model: transfer list, addresses and side effects from the ISA rules.
    eff = (list == 16'h0) ? 16'h8000 : list;
    for (int i = 0; i < 16; i++) if (eff[i]) q.push_back(i);
    b    = base & 32'hFFFF_FFFC;
    span = (list == 16'h0) ? 32'h40 : 32'(4 * q.size());
    if (a_u) addr = a_p ? b + 32'd4 : b;
    else     addr = a_p ? b - span : b - span + 32'd4;
    wbd    = a_u ? b + span : b - span;
    wben   = a_w && !(ld && eff[rn]);
    user_e = a_s && !(ld && list[15]);
    spsr_e = a_s && ld && eff[15];

    start = 1'b1; is_load = ld; P = a_p; U = a_u; S = a_s; W = a_w;
    reg_list = list; rn_idx = rn; base_addr = base; mem_ack = 1'b0;
    tick();
    start = 1'b0;

    k = 0; waited = 0; cyc = 0; pend_rf = 0; pend_wb = 0; pidx = '0; pdata = '0;
    nwait = $urandom_range(maxwait, 0);
    while (k < q.size()) begin
      if (cyc >= 400) begin
        chk("xfer_timeout_cycles", cyc, 0);
        return;
      end
      chk("busy", busy, 1);
      chk("mem_req", mem_req, 1);
      chk("mem_addr", mem_addr, addr);
      chk("reg_idx", reg_idx, q[k]);
      chk("mem_we", mem_we, !ld);
      if (!ld) chk("mem_wdata", mem_wdata, 32'h5A5A_0000 | q[k]);
      chk("user_bank", user_bank, user_e);
      chk("done", done, 0);
      chk("spsr_restore", spsr_restore, 0);
      chk_writes(pend_rf, pidx, pdata, pend_wb, wbd);
      if (abort_at >= 0 && k == abort_at) begin
        mem_ack = 1'b1;
        reset   = 1'b1;
        tick();
        reset   = 1'b0;
        mem_ack = 1'b0;
        chk_all_zero("after_reset");
        return;
      end
      ack       = (waited >= nwait);
      mem_ack   = ack;
      mem_rdata = $urandom;
      if (junk_start && $urandom_range(1, 0) == 1) begin
        start = 1'b1; is_load = $urandom; P = $urandom; U = $urandom; S = $urandom;
        W = $urandom; reg_list = $urandom; rn_idx = $urandom; base_addr = $urandom;
      end
      pend_rf = ack && ld;
      pidx    = q[k][3:0];
      pdata   = mem_rdata;
      pend_wb = ack && (k == 0) && wben;
      tick();
      start = 1'b0;
      cyc++;
      if (ack) begin
        k++;
        addr   = addr + 32'd4;
        waited = 0;
        nwait  = $urandom_range(maxwait, 0);
      end else begin
        waited++;
      end
    end

    // Completion cycle; a stray ack here must have no effect.
    mem_ack = $urandom;
    chk("fin.busy", busy, 1);
    chk("fin.mem_req", mem_req, 0);
    chk("fin.done", done, 1);
    chk("fin.spsr_restore", spsr_restore, spsr_e);
    chk("fin.user_bank", user_bank, user_e);
    chk_writes(pend_rf, pidx, pdata, pend_wb, wbd);
    tick();
    mem_ack = 1'b0;
    chk("idle.busy", busy, 0);
    chk("idle.done", done, 0);
    chk("idle.mem_req", mem_req, 0);
    chk("idle.rf_we", rf_we, 0);
    chk("idle.wb_we", wb_we, 0);
    chk("idle.user_bank", user_bank, 0);
    chk("idle.spsr_restore", spsr_restore, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] list;
    reset = 1'b1; start = 1'b0; is_load = 1'b0; P = 1'b0; U = 1'b0; S = 1'b0; W = 1'b0;
    reg_list = '0; rn_idx = '0; base_addr = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    // STMIA R4-R7, writeback
    run_op(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00F0, 4'd1, 32'h0300_0000, 0, 1'b0, -1);
    // LDMDB R0,R1,R15 with S: user_bank 0, load_pc and spsr_restore
    run_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h8003, 4'd13, 32'h0300_0100, 0, 1'b0, -1);
    // LDMIA with Rn in the list: no writeback
    run_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0004, 4'd2, 32'h0000_2000, 0, 1'b0, -1);
    // Empty-list STMIB: single R15 store, 0x40 stride
    run_op(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 4'd3, 32'h0000_0100, 0, 1'b0, -1);
    // Wait states with stray start pulses
    run_op(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1281, 4'd7, 32'h1000_0040, 3, 1'b1, -1);
    // Base wrap-around on decrement
    run_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h000F, 4'd9, 32'h0000_0008, 0, 1'b0, -1);
    // Reset during the second transfer, then a normal operation
    run_op(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00F0, 4'd1, 32'h0400_0000, 0, 1'b0, 1);
    run_op(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0C30, 4'd4, 32'h0500_0000, 0, 1'b0, -1);

    for (int t = 0; t < 24; t++) begin
      list = 16'($urandom);
      if ($urandom_range(7, 0) == 0) list = 16'h0;
      run_op($urandom, $urandom, $urandom, $urandom, $urandom, list, 4'($urandom),
             $urandom, 2, $urandom, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/arm_block_transfer_sequencer.md
# arm_block_transfer_sequencer

Multi-cycle sequencer that executes ARM LDM/STM instructions. It consumes the block-transfer fields of a decoded instruction word (P, U, S, W, reg_list, Rn) and the current base value. It then issues one 32-bit memory request per listed register, in ascending register order, and drives register-file writes for loads and the base-register writeback. It sits between the decoder/control unit and the bus interface, and owns the CPU pipeline while `busy` is high.

## Interface
Parameters:
- `EMPTY_LIST_QUIRK`, default 1: when 1, an empty reg_list transfers R15 only and adjusts the base by 0x40 (ARMv4 behaviour). When 0, an empty list completes immediately with no transfers and no writeback.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle launch. Sampled only in IDLE.
- `is_load` in 1: 1 = LDM, 0 = STM.
- `P` in 1: pre_post_offset_flag_t.
- `U` in 1: 1 = increment, 0 = decrement.
- `S` in 1: PSR / force-user bit.
- `W` in 1: writeback enable.
- `reg_list` in 16: register list.
- `rn_idx` in 4: base register index.
- `base_addr` in 32: value of Rn, sampled at `start`.
- `store_data` in 32: register-file read data for `reg_idx`.
- `mem_ack` in 1: bus accepted the current request. For loads, `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: load data.
- `busy` out 1: sequencer active.
- `mem_req` out 1: request valid.
- `mem_we` out 1: store request.
- `mem_addr` out 32: word address, with bits [1:0] always 0.
- `mem_wdata` out 32: equals `store_data` (combinational).
- `reg_idx` out 4: register of the current transfer.
- `rf_we` out 1, `rf_idx` out 4, `rf_wdata` out 32: load write port.
- `wb_we` out 1, `wb_data` out 32: base writeback.
- `user_bank` out 1: access user-mode registers for this transfer.
- `load_pc` out 1: pulses with an `rf_we` that targets R15.
- `spsr_restore` out 1: pulses with `done` when S=1, is_load=1 and R15 is in the list.
- `done` out 1: one-cycle completion pulse.

## Operation
- FSM states: IDLE, XFER, FINISH.
  - IDLE → XFER on `start`.
  - XFER → FINISH on `mem_ack` for the last register.
  - FINISH → IDLE unconditionally.
- `start` is ignored while busy. `mem_ack` is ignored when `mem_req` is 0.
- n = popcount(reg_list). For an empty list with the quirk enabled, n is treated as 1 (R15) and the stride is 0x40.
- Start address, using B = base_addr[31:2]<<2:
  - IA (P=0, U=1): B
  - IB (P=1, U=1): B+4
  - DA (P=0, U=0): B−4n+4
  - DB (P=1, U=0): B−4n
  - Empty list: IA B, IB B+4, DA B−0x3C, DB B−0x40.
- Register order is always lowest index first. Each accepted transfer adds 4 to the address, with 32-bit wrap-around.
- `wb_data` = U ? B+4n : B−4n, or B±0x40 for an empty list.
- Writeback rules:
  - `wb_we` pulses once, in the cycle after the first `mem_ack`, only if W=1.
  - For LDM with Rn in the list, writeback is suppressed.
  - For STM, a later store of Rn therefore sees the new base; a store of Rn as the first register sees the old base.
- `user_bank` = S && !(is_load && reg_list[15]). It is latched at `start` and held while busy.
- For loads, `rf_we`/`rf_idx`/`rf_wdata` are registered: they are asserted in the cycle after `mem_ack`, carrying the acked register and `mem_rdata`.
- Reset in any state returns to IDLE. All outputs are 0 in the following cycle. Pending writebacks and register writes are dropped.

## Timing
- Reset value of all outputs: 0.
- `start` in cycle 0 → `busy` and `mem_req` high from cycle 1, with the first address.
- `mem_req` is held, with address stable, until `mem_ack`. The next request is presented in the cycle after the ack.
- With `mem_ack` held high, n transfers occupy cycles 1..n. FINISH is cycle n+1, in which `done` pulses and `busy` is still high. `busy` is 0 in cycle n+2.
- The final load's `rf_we` coincides with `done`.
- `spsr_restore` coincides with `done`.
- Earliest restart: a `start` in cycle n+2 is accepted.

## Structure
- The shared CPU decoder package gains:
  - `block_mode_t` enum {IA, IB, DA, DB}, derived from {P, U}.
  - Constant `EMPTY_LIST_STRIDE` = 32'h40.
- `pre_post_offset_flag_t` is reused from the same package.
- Sub-module `reg_list_scan`: combinational lowest-set-bit finder plus popcount over 16 bits. It is instantiated once, on the remaining-list register; each accepted transfer clears the lowest bit.

## Test plan
- STMIA, base 0x0300_0000, list 0x00F0, W=1, ack always high → stores of R4..R7 to 0x0300_0000/04/08/0C in cycles 1..4; `wb_data` 0x0300_0010 pulsed in cycle 2; `done` in cycle 5.
- LDMDB, base 0x0300_0100, list 0x8003, W=1, S=1, mem_rdata = address → loads from 0x0300_00F4/F8/FC into R0, R1, R15; `load_pc` pulses on the final write; `user_bank` = 0; `spsr_restore` pulses with `done`; `wb_data` 0x0300_00F4.
- LDMIA, Rn = R2, list 0x0004, W=1 → R2 loaded from base; `wb_we` never asserted.
- Empty-list STMIB, base 0x100 → a single store of R15 to 0x104; `wb_data` 0x140.
- Wait states: `mem_ack` low for 3 cycles on each transfer → `mem_addr`/`reg_idx` stay stable while waiting; `start` asserted mid-operation is ignored.
- `reset` asserted in the 2nd transfer → IDLE next cycle with all outputs 0 and no `wb_we`; a new `start` is then accepted normally.
